// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Purpose  : Generic elastic pipeline-stage register. Carries an opaque
//             WIDTH-bit bundle between core stages over a valid/ready
//             handshake, backed by a two-entry (main + skid) buffer so that
//             in_ready is a pure flop output and throughput stays at one
//             bundle per cycle. A synchronous flush injects the CLEAR_VAL
//             bubble, and a saturating counter records downstream stalls.
//  Ports    : clk, rst_n              clock / async active-low reset
//             in_valid, in_ready,     upstream handshake and bundle
//             in_data
//             out_valid, out_ready,   downstream handshake and bundle
//             out_data                (out_data = CLEAR_VAL when !out_valid)
//             flush                   synchronous stage clear
//             occupancy               entries held (0, 1 or 2)
//             cnt_clr, stall_cnt      stall counter clear / value
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int                 WIDTH     = 64,
  parameter logic [WIDTH-1:0]   CLEAR_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic               flush,
  output logic [1:0]         occupancy,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   main_data;
  logic [WIDTH-1:0]   main_nxt;
  logic [WIDTH-1:0]   skid_data;
  logic [WIDTH-1:0]   skid_nxt;
  logic               ready_q;
  logic               in_xfer;
  logic               out_xfer;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign occupancy = state;
  assign in_ready  = ready_q;

  assign in_xfer   = in_valid & ready_q;
  assign out_xfer  = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // State and storage registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= CLEAR_VAL;
      skid_data <= CLEAR_VAL;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      main_data <= main_nxt;
      skid_data <= skid_nxt;
      // in_ready is precomputed from the next state so that it leaves a
      // flop directly; out_ready never reaches it combinationally.
      ready_q   <= (state_nxt != TWO);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-data logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;

    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end

      ONE: begin
        if (in_xfer && out_xfer) begin
          main_nxt  = in_data;
        end else if (in_xfer) begin
          // Downstream stalled: park the new bundle behind the current one.
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
          main_nxt  = CLEAR_VAL;
        end
      end

      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          state_nxt = ONE;
          main_nxt  = skid_data;
          skid_nxt  = CLEAR_VAL;
        end
      end

      default: begin
        state_nxt = EMPTY;
        main_nxt  = CLEAR_VAL;
        skid_nxt  = CLEAR_VAL;
      end
    endcase

    // Flush overrides everything. An output transfer in the same cycle has
    // already been sampled downstream, and any input transfer is dropped.
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = CLEAR_VAL;
      skid_nxt  = CLEAR_VAL;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall counter (independent of flush)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_buf
//  Purpose  : Directed self-checking bench for pipe_stage_buf with
//             WIDTH=16, CLEAR_VAL=16'h0001, CNT_W=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int          WIDTH = 16;
  localparam int          CNT_W = 4;
  localparam logic [15:0] CLR   = 16'h0001;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              flush;
  logic [1:0]        occupancy;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  pipe_stage_buf #(
    .WIDTH     (WIDTH),
    .CLEAR_VAL (CLR),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance through one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    step();
    in_data   = 16'h6666;
    step();
    compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL reset_preload_occ: got %0d want 2", occupancy); end
    compared++; if (stall_cnt !== 4'd1) begin mismatched++; $display("FAIL reset_preload_cnt: got %0d want 1", stall_cnt); end
    // Assert reset mid-cycle, well away from any edge.
    #2 rst_n = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (out_data !== CLR) begin mismatched++; $display("FAIL reset_out_data: got %h want %h", out_data, CLR); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_after_release: got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [15:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp      = 16'hA000 + 16'(i);
      in_valid = 1'b1;
      in_data  = exp;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      compared++; if (out_valid !== 1'b1 || out_data !== exp) begin mismatched++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp); end
    end
    in_valid = 1'b0;
    step();
    compared++; if (out_valid !== 1'b0 || out_data !== CLR) begin mismatched++; $display("FAIL stream_drain: got v=%b d=%h want v=0 d=%h", out_valid, out_data, CLR); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    step();
    compared++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_first: got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
    in_data = 16'h2222;
    step();
    compared++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_second: got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
    in_data = 16'h3333;
    step();
    compared++; if (occupancy !== 2'd2 || out_data !== 16'h1111) begin mismatched++; $display("FAIL bp_refuse: got occ=%0d d=%h want occ=2 d=1111", occupancy, out_data); end
    out_ready = 1'b1;   // 16'h1111 consumed at the next edge
    step();
    compared++; if (out_data !== 16'h2222 || in_ready !== 1'b1 || occupancy !== 2'd1) begin mismatched++; $display("FAIL bp_release1: got d=%h rdy=%b occ=%0d want d=2222 rdy=1 occ=1", out_data, in_ready, occupancy); end
    step();
    compared++; if (out_data !== 16'h3333 || out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_release2: got v=%b d=%h want v=1 d=3333", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    compared++; if (stall_cnt !== 4'd2) begin mismatched++; $display("FAIL bp_stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    step();
    in_data = 16'hCAFE;
    step();
    compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    in_data = 16'hDEAD;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    compared++; if (out_valid !== 1'b0 || out_data !== CLR) begin mismatched++; $display("FAIL flush_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, CLR); end
    compared++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_state: got occ=%0d rdy=%b want occ=0 rdy=1", occupancy, in_ready); end
    compared++; if (stall_cnt !== 4'd4) begin mismatched++; $display("FAIL flush_keeps_cnt: got %0d want 4", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_no_emerge[%0d]: got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
    // Flush together with an input transfer in EMPTY, plus cnt_clr.
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    flush    = 1'b1;
    cnt_clr  = 1'b1;
    step();
    flush    = 1'b0;
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    compared++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_empty_input: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL flush_cnt_clr: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_stall_counter();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h4444;
    step();
    in_valid = 1'b0;
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL stall_start: got %0d want 0", stall_cnt); end
    for (int i = 0; i < 14; i++) step();
    compared++; if (stall_cnt !== 4'd14) begin mismatched++; $display("FAIL stall_14: got %0d want 14", stall_cnt); end
    for (int i = 0; i < 6; i++) step();
    compared++; if (stall_cnt !== 4'd15) begin mismatched++; $display("FAIL stall_sat: got %0d want 15", stall_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL stall_clr: got %0d want 0", stall_cnt); end
    step();
    compared++; if (stall_cnt !== 4'd1) begin mismatched++; $display("FAIL stall_resume: got %0d want 1", stall_cnt); end
    out_ready = 1'b1;
    step();
    compared++; if (stall_cnt !== 4'd1 || out_valid !== 1'b0) begin mismatched++; $display("FAIL stall_drain: got cnt=%0d v=%b want cnt=1 v=0", stall_cnt, out_valid); end
  endtask

  task automatic test_drain_bubble();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    step();
    in_valid = 1'b0;
    compared++; if (out_valid !== 1'b1 || out_data !== 16'h7777) begin mismatched++; $display("FAIL bubble_present: got v=%b d=%h want v=1 d=7777", out_valid, out_data); end
    step();
    compared++; if (out_valid !== 1'b0 || out_data !== CLR) begin mismatched++; $display("FAIL bubble_clear: got v=%b d=%h want v=0 d=%h", out_valid, out_data, CLR); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    #23 rst_n = 1'b1;
    step();

    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_counter();
    test_drain_bubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised, elastic pipeline-stage register for the pipelined core, replacing fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque WIDTH-bit bundle of control and data fields between stages using a valid/ready handshake, with a two-entry skid buffer. It provides:
- full throughput with no combinational ready path;
- a synchronous flush that injects a programmable bubble (NOP) value;
- a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- WIDTH, 64: bit width of the carried bundle (≥1).
- CLEAR_VAL, {WIDTH{1'b0}}: bubble value. Loaded on reset and flush, and presented whenever out_valid=0. Lets control bits such as a "run" bit be 1 in a bubble.
- CNT_W, 16: stall counter width (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  block can accept; registered.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  bundle presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  bundle to downstream; equals CLEAR_VAL when out_valid=0.
- flush  in  1  synchronous clear of the stage (branch mispredict, call/ret redirect).
- occupancy  out  2  entries held: 0, 1 or 2.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage:
  - main register (drives out_data) with main_valid;
  - skid register with skid_valid.
- Output and ready mapping:
  - out_valid = main_valid.
  - in_ready = !skid_valid, taken directly from a flop.
- Transfers:
  - an input transfer occurs when in_valid & in_ready;
  - an output transfer occurs when out_valid & out_ready.
- States, with occupancy = 0, 1, 2 respectively:
  - EMPTY: main and skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- Transitions (flush=0):
  - EMPTY: input transfer → ONE, main ← in_data. Otherwise stay, main holds CLEAR_VAL.
  - ONE, input and output transfer → ONE, main ← in_data.
  - ONE, input transfer only → TWO, skid ← in_data, main holds.
  - ONE, output transfer only → EMPTY, main ← CLEAR_VAL.
  - ONE, neither → hold.
  - TWO: in_ready=0, so no input transfer. Output transfer → ONE, main ← skid, skid ← CLEAR_VAL. Otherwise hold.
- Flush (highest priority, regardless of state or handshakes):
  - next state EMPTY;
  - main and skid ← CLEAR_VAL, both valids ← 0;
  - any input transfer in the flush cycle is discarded;
  - an output transfer in the flush cycle still completes, because downstream sampled the current out_data.
- Stall counter:
  - increments when out_valid & !out_ready, saturates at 2^CNT_W−1;
  - cnt_clr loads 0 and has priority over increment;
  - flush does not affect stall_cnt.
- Ordering: data is delivered strictly in FIFO order. No bundle is duplicated or lost except by flush.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - out_valid=0, out_data=CLEAR_VAL;
  - skid data = CLEAR_VAL, skid_valid=0;
  - in_ready=1, occupancy=0, stall_cnt=0.
- Release of rst_n is synchronous to clk. The first input transfer is possible on the first rising edge after release.
- Latency: an input accepted at edge N appears on out_data/out_valid after edge N, for consumption at edge N+1.
- Throughput: one bundle per cycle while out_ready=1 continuously.
- in_ready:
  - drops the cycle after a TWO entry;
  - rises the cycle after the first output transfer in TWO.
- No combinational path from out_ready to in_ready, or from in_data to out_data.
- Reset asserted mid-operation discards all content immediately, with no waiting for a clock edge.
- Simultaneous events:
  - flush + cnt_clr: both apply.
  - flush + input transfer in EMPTY: the stage stays EMPTY.

## Test plan
Conditions for every scenario: WIDTH=16, CLEAR_VAL=16'h0001, CNT_W=4.
- Reset: assert rst_n=0 mid-cycle with data held → out_valid=0, out_data=16'h0001, in_ready=1, occupancy=0, stall_cnt=0, all immediately, before any edge.
- Streaming: with out_ready=1, feed 16'hA000..16'hA009 on consecutive cycles → the same 10 values appear in order, each one cycle after acceptance, with no bubbles and in_ready constantly 1.
- Backpressure/skid:
  - stimulus: hold out_ready=0, present 16'h1111 then 16'h2222;
  - response: occupancy 1 then 2, in_ready=0 after the second acceptance, 16'h3333 is not accepted;
  - release: raise out_ready → out 16'h1111, then 16'h2222, then 16'h3333 once accepted.
- Flush:
  - stimulus: in TWO holding 16'hBEEF/16'hCAFE, assert flush together with in_valid for 16'hDEAD;
  - response next cycle: out_valid=0, out_data=16'h0001, occupancy=0, in_ready=1, and 16'hDEAD never emerges.
- Stall counter:
  - out_valid=1 with out_ready=0 for 20 cycles → stall_cnt=15 (saturated);
  - cnt_clr together with a stall → 0 next cycle, then counting resumes at 1.
- Drain bubble: single bundle 16'h7777 consumed with no new input → out_valid=0 and out_data returns to 16'h0001 the next cycle.
